// File: rtl/vga_sync_decoder_pkg.sv
// rtl/vga_sync_decoder_pkg.sv - default 640x480@60 timing, counter limits and lock FSM states
package vga_sync_decoder_pkg;

  // Default horizontal timing in pixel clocks
  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;

  // Default vertical timing in lines
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  // The column counter parks here when HSYNC disappears
  localparam logic [10:0] HCNT_MAX = 11'd2047;
  localparam logic [7:0]  ERR_MAX  = 8'd255;

  // Lock progression shared with the sync generators
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_t;

endpackage

// File: rtl/vga_sync_decoder_sync_sampler.sv
// rtl/vga_sync_decoder_sync_sampler.sv - registers one sync input and flags its falling edge
module vga_sync_decoder_sync_sampler (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic fall
);

  logic level;
  logic level_d;

  // Single capture stage plus a one-clock delayed copy for edge detection.
  // Both reset low so a sync line that is already low after reset is not
  // mistaken for a fresh falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      level   <= din;
      level_d <= level;
    end
  end

  assign fall = level_d & ~level;

endmodule

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - checks HSYNC/VSYNC against configured timing and recovers pixel coordinates
module vga_sync_decoder
  import vga_sync_decoder_pkg::*;
#(
  parameter int H_VIS  = DEF_H_VIS,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_VIS  = DEF_V_VIS,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       VGA_HSYNC,
  input  logic       VGA_VSYNC,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       active,
  output logic       locked,
  output logic       frame_start,
  output logic       timing_error,
  output logic [7:0] err_count
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_OFF   = H_SYNC + H_BP;
  localparam int V_OFF   = V_SYNC + V_BP;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_END   = 11'(H_TOTAL);
  localparam logic [10:0] H_START = 11'(H_OFF);
  localparam logic [10:0] H_STOP  = 11'(H_OFF + H_VIS);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_START = 10'(V_OFF);
  localparam logic [9:0]  V_STOP  = 10'(V_OFF + V_VIS);

  logic        hs_fall;
  logic        vs_fall;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic        h_valid;
  logic        vs_pending;
  sync_state_t state;
  sync_state_t state_n;

  logic        frame_edge;
  logic        checking;
  logic        line_err;
  logic        frame_err;
  logic        frame_ok;
  logic        fail;
  logic        h_in;
  logic        v_in;
  logic        act_n;
  logic [10:0] hoff;
  logic [9:0]  voff;

  vga_sync_decoder_sync_sampler u_hs (
    .clk   (clk),
    .reset (reset),
    .din   (VGA_HSYNC),
    .fall  (hs_fall)
  );

  vga_sync_decoder_sync_sampler u_vs (
    .clk   (clk),
    .reset (reset),
    .din   (VGA_VSYNC),
    .fall  (vs_fall)
  );

  // A line that starts a new frame: pending vsync, or vsync falling on the same sample
  assign frame_edge = hs_fall & (vs_pending | vs_fall);

  // Checks only make sense once a line start has been seen and we are tracking
  assign checking  = h_valid & (state != SEARCH);
  assign line_err  = checking & (hs_fall ? (hcnt != H_LAST) : (hcnt == H_END));
  assign frame_err = checking & frame_edge & (vcnt != V_LAST);
  assign frame_ok  = checking & frame_edge & (vcnt == V_LAST);
  assign fail      = line_err | frame_err;

  // Column counter restarts on each line start and parks at its maximum if sync is lost
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt    <= '0;
      h_valid <= 1'b0;
    end else if (hs_fall) begin
      hcnt    <= '0;
      h_valid <= 1'b1;
    end else if (hcnt != HCNT_MAX) begin
      hcnt <= hcnt + 11'd1;
    end
  end

  // Row counter advances per line; a remembered vsync edge restarts it on the next line
  always_ff @(posedge clk) begin
    if (reset) begin
      vcnt       <= '0;
      vs_pending <= 1'b0;
    end else if (hs_fall) begin
      vcnt       <= (vs_pending | vs_fall) ? 10'd0 : vcnt + 10'd1;
      vs_pending <= 1'b0;
    end else if (vs_fall) begin
      vs_pending <= 1'b1;
    end
  end

  // Lock state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEARCH;
    end else begin
      state <= state_n;
    end
  end

  // Lock progression: first frame edge starts a measurement, a clean frame locks, any failure drops out
  always_comb begin
    state_n = state;
    case (state)
      SEARCH: begin
        if (frame_edge) begin
          state_n = MEASURE;
        end
      end
      MEASURE: begin
        if (fail) begin
          state_n = SEARCH;
        end else if (frame_ok) begin
          state_n = LOCKED;
        end
      end
      LOCKED: begin
        if (fail) begin
          state_n = SEARCH;
        end
      end
      default: begin
        state_n = SEARCH;
      end
    endcase
  end

  // Visible window decode; gating with the next state lets active fall together with locked
  always_comb begin
    h_in  = (hcnt >= H_START) && (hcnt < H_STOP);
    v_in  = (vcnt >= V_START) && (vcnt < V_STOP);
    act_n = (state_n == LOCKED) && h_in && v_in;
    hoff  = hcnt - H_START;
    voff  = vcnt - V_START;
  end

  // Registered outputs, one clock behind the counters
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos         <= '0;
      vpos         <= '0;
      active       <= 1'b0;
      locked       <= 1'b0;
      frame_start  <= 1'b0;
      timing_error <= 1'b0;
      err_count    <= '0;
    end else begin
      hpos         <= act_n ? hoff[9:0] : 10'd0;
      vpos         <= act_n ? voff : 10'd0;
      active       <= act_n;
      locked       <= (state_n == LOCKED);
      frame_start  <= act_n && (hcnt == H_START) && (vcnt == V_START);
      timing_error <= fail;
      if (fail && (err_count != ERR_MAX)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - self-checking bench for vga_sync_decoder with a reduced timing set
module tb_vga_sync_decoder;

  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HS = 4;
  localparam int HB = 2;
  localparam int VV = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int HO = HS + HB;
  localparam int VO = VS + VB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       VGA_HSYNC = 1'b1;
  logic       VGA_VSYNC = 1'b1;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       active;
  logic       locked;
  logic       frame_start;
  logic       timing_error;
  logic [7:0] err_count;

  vga_sync_decoder #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .VGA_HSYNC    (VGA_HSYNC),
    .VGA_VSYNC    (VGA_VSYNC),
    .hpos         (hpos),
    .vpos         (vpos),
    .active       (active),
    .locked       (locked),
    .frame_start  (frame_start),
    .timing_error (timing_error),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hpos;
    int vpos;
    bit active;
    bit locked;
    bit fs;
    bit te;
    int ec;
  } exp_t;

  exp_t exp_r [4];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  // Model: timestamps of sync edges, line count in frame, lock level 0/1/2
  int m_last_hf;
  int m_lines;
  int m_state;
  int m_errs;
  bit m_armed;
  bit m_hs_prev;
  bit m_vs_prev;

  int fs_seen = 0;
  int te_seen = 0;
  int act_seen = 0;
  int mark_t = -100;
  int mark_h = 0;
  int mark_v = 0;
  int mark_a = 0;

  function automatic exp_t zero_exp();
    exp_t z;
    z.hpos = 0; z.vpos = 0; z.active = 0; z.locked = 0; z.fs = 0; z.te = 0; z.ec = 0;
    return z;
  endfunction

  task automatic model_reset();
    m_last_hf = cyc - 1;
    m_lines   = 0;
    m_state   = 0;
    m_errs    = 0;
    m_armed   = 0;
    m_hs_prev = 0;
    m_vs_prev = 0;
  endtask

  // Sample t is seen by the DUT at edge t; its consequences appear at edge t+1,
  // together with the coordinates of sample t-1 (two clocks of total latency).
  task automatic model_sample(input bit hs, input bit vs);
    int   t;
    int   col;
    int   row;
    bit   hf;
    bit   vf;
    bit   boundary;
    bit   bad;
    bit   good;
    exp_t e;
    t   = cyc;
    col = t - 1 - m_last_hf;
    if (col > 2047) col = 2047;
    row = m_lines % 1024;
    hf = m_hs_prev && !hs;
    vf = m_vs_prev && !vs;
    boundary = hf && (m_armed || vf);
    bad  = 0;
    good = 0;
    if (m_state != 0) begin
      if (hf) begin
        if (t - m_last_hf != HT) bad = 1;
      end else if (t - 1 - m_last_hf == HT) begin
        bad = 1;
      end
      if (boundary) begin
        if (m_lines + 1 == VT) good = 1;
        else bad = 1;
      end
    end
    if (bad) begin
      m_state = 0;
      if (m_errs < 255) m_errs++;
    end else if (m_state == 0 && boundary) begin
      m_state = 1;
    end else if (m_state == 1 && good) begin
      m_state = 2;
    end
    if (hf) begin
      m_last_hf = t;
      m_lines   = boundary ? 0 : m_lines + 1;
      m_armed   = 0;
    end else if (vf) begin
      m_armed = 1;
    end
    e.locked = (m_state == 2);
    e.active = e.locked && col >= HO && col < HO + HV && row >= VO && row < VO + VV;
    e.hpos   = e.active ? col - HO : 0;
    e.vpos   = e.active ? row - VO : 0;
    e.fs     = e.active && col == HO && row == VO;
    e.te     = bad;
    e.ec     = m_errs;
    exp_r[(t + 1) % 4] = e;
    m_hs_prev = hs;
    m_vs_prev = vs;
  endtask

  task automatic check_edge(input int e);
    exp_t       x;
    logic [9:0] eh;
    logic [9:0] ev;
    logic [7:0] ee;
    x  = exp_r[e % 4];
    eh = x.hpos[9:0];
    ev = x.vpos[9:0];
    ee = x.ec[7:0];
    n_tests++;
    if (hpos !== eh || vpos !== ev || active !== x.active || locked !== x.locked ||
        frame_start !== x.fs || timing_error !== x.te || err_count !== ee) begin
      n_fail++;
      $display("FAIL cycle_%0d: got hpos=%0d vpos=%0d act=%0b lock=%0b fs=%0b te=%0b ec=%0d, want hpos=%0d vpos=%0d act=%0b lock=%0b fs=%0b te=%0b ec=%0d",
               e, hpos, vpos, active, locked, frame_start, timing_error, err_count,
               eh, ev, x.active, x.locked, x.fs, x.te, ee);
    end
    fs_seen  += int'(frame_start);
    te_seen  += int'(timing_error);
    act_seen += int'(active);
    if (e == mark_t + 2) begin
      mark_h = int'(hpos);
      mark_v = int'(vpos);
      mark_a = int'(active);
    end
  endtask

  task automatic lit(input string name, input int actual, input int required);
    n_tests++;
    if (actual != required) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, actual, required);
    end
  endtask

  task automatic step(input bit hs, input bit vs);
    VGA_HSYNC = hs;
    VGA_VSYNC = vs;
    model_sample(hs, vs);
    @(posedge clk);
    @(negedge clk);
    check_edge(cyc);
    cyc++;
  endtask

  task automatic rst_step();
    reset = 1'b1;
    model_reset();
    exp_r[cyc % 4]       = zero_exp();
    exp_r[(cyc + 1) % 4] = zero_exp();
    @(posedge clk);
    @(negedge clk);
    check_edge(cyc);
    cyc++;
    reset = 1'b0;
  endtask

  // Sync generator: sync, back porch, visible, front porch per line; vsync spans first VS lines
  task automatic gen_frame(input int nlines, input int stretch, input bit mark);
    int len;
    for (int l = 0; l < nlines; l++) begin
      len = HT + ((l == stretch) ? 1 : 0);
      for (int c = 0; c < len; c++) begin
        if (mark && l == VO + 2 && c == HO + 3) mark_t = cyc;
        step((c < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1);
      end
    end
  endtask

  int fs0;
  int te0;
  int act0;

  initial begin
    @(negedge clk);
    rst_step();
    rst_step();
    lit("reset_locked", int'(locked), 0);
    lit("reset_err_count", int'(err_count), 0);
    lit("reset_active", int'(active), 0);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    gen_frame(VT, -1, 1'b0);
    lit("measuring_not_locked", int'(locked), 0);
    fs0 = fs_seen;
    gen_frame(VT, -1, 1'b0);
    lit("locked_after_clean_frame", int'(locked), 1);
    lit("frame_start_first_locked_frame", fs_seen - fs0, 1);

    fs0 = fs_seen;
    gen_frame(VT, -1, 1'b1);
    lit("pixel_hpos", mark_h, 3);
    lit("pixel_vpos", mark_v, 2);
    lit("pixel_active", mark_a, 1);
    lit("frame_start_once", fs_seen - fs0, 1);
    lit("no_errors_clean", int'(err_count), 0);

    te0 = te_seen;
    gen_frame(VT, 4, 1'b0);
    lit("stretch_error_pulse", te_seen - te0, 1);
    lit("stretch_err_count", int'(err_count), 1);
    lit("stretch_unlocked", int'(locked), 0);

    gen_frame(VT, -1, 1'b0);
    gen_frame(VT, -1, 1'b0);
    lit("relock_after_stretch", int'(locked), 1);

    gen_frame(VT + 1, -1, 1'b0);
    act0 = act_seen;
    gen_frame(VT, -1, 1'b0);
    lit("long_frame_err_count", int'(err_count), 2);
    lit("long_frame_no_active", act_seen - act0, 0);
    lit("long_frame_unlocked", int'(locked), 0);
    gen_frame(VT, -1, 1'b0);
    gen_frame(VT, -1, 1'b0);
    lit("relock_after_long_frame", int'(locked), 1);

    te0 = te_seen;
    for (int i = 0; i < HT + 100; i++) step(1'b1, 1'b1);
    lit("hsync_lost_single_error", te_seen - te0, 1);
    lit("hsync_lost_err_count", int'(err_count), 3);

    gen_frame(VT, -1, 1'b0);
    gen_frame(VT, -1, 1'b0);
    gen_frame(VO + 2, -1, 1'b0);
    for (int i = 0; i < HO + 2; i++) step(1'b0 == 1'b1, 1'b1);
    lit("pre_reset_locked", int'(locked), 1);
    rst_step();
    lit("midreset_locked", int'(locked), 0);
    lit("midreset_active", int'(active), 0);
    lit("midreset_err_count", int'(err_count), 0);

    te0 = te_seen;
    for (int k = 0; k < 300; k++) begin
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      for (int i = 0; i < HT + 2; i++) step(1'b0, 1'b1);
    end
    lit("forced_error_pulses", te_seen - te0, 300);
    lit("err_count_saturates", int'(err_count), 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the Hsync/Vsync timing generators: samples VGA_HSYNC and VGA_VSYNC, checks the pulse train against the configured 640x480@60 timing, locks after one clean frame, and outputs recovered pixel coordinates with an active-video flag. It sits on the loopback path as a self-checker for the sync generators and as the front end for any block that consumes a VGA-timed stream.

## Interface
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- clk  in  1  pixel clock, one sample per clock
- reset  in  1  synchronous, active-high
- VGA_HSYNC  in  1  horizontal sync, active low
- VGA_VSYNC  in  1  vertical sync, active low
- hpos  out  10  recovered column, 0..H_VIS-1; 0 when not active
- vpos  out  10  recovered row, 0..V_VIS-1; 0 when not active
- active  out  1  current sample is a visible pixel (only while locked)
- locked  out  1  timing verified
- frame_start  out  1  one-cycle pulse on pixel (0,0) while locked
- timing_error  out  1  one-cycle pulse on any check failure
- err_count  out  8  saturating count of timing_error pulses

## Operation
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525); H_OFF = H_SYNC+H_BP; V_OFF = V_SYNC+V_BP.
- Inputs registered once (s_hs, s_vs) plus a delayed copy; hs_fall = s_hs_d & ~s_hs, vs_fall likewise.
- hcnt (11 b): 0 on clock after hs_fall, else +1, saturates at 2047. h_valid set on first hs_fall after reset.
- vcnt (10 b): on hs_fall +1, or 0 if vs_pending. vs_fall sets vs_pending; cleared by next hs_fall. vs_fall and hs_fall in the same cycle: vcnt <= 0 on that hs_fall.
- Checks (only when h_valid already set): at hs_fall, hcnt must equal H_TOTAL-1; hcnt reaching H_TOTAL without hs_fall is a failure (lost sync); at the hs_fall consuming vs_pending, vcnt must equal V_TOTAL-1.
- FSM: SEARCH (reset) -> MEASURE on the hs_fall consuming vs_pending, no frame check on this transition. MEASURE -> LOCKED when the next frame check passes with no line failure in between. MEASURE or LOCKED -> SEARCH on any failure, with timing_error pulse and err_count+1 (saturates at 255). SEARCH performs no checks and pulses no error.
- Outputs registered from counters: active = LOCKED & hcnt in [H_OFF, H_OFF+H_VIS) & vcnt in [V_OFF, V_OFF+V_VIS); hpos = hcnt-H_OFF, vpos = vcnt-V_OFF when active, else 0. frame_start = active & hpos==0 & vpos==0. locked = (state==LOCKED).

## Timing
- Reset: all outputs 0, state SEARCH, counters 0, h_valid 0, vs_pending 0.
- VGA_HSYNC low first sampled at edge t: hcnt = 0 after edge t+1; outputs for that hcnt after edge t+2. Total input-to-output latency 2 clocks.
- locked rises in the output register cycle after the passing frame check; falls the cycle after a failing check, same cycle timing_error pulses; active drops with it.
- Reset mid-frame: back to SEARCH; err_count cleared.

## Structure
- Shared header vga_timing.vh: default H/V timing constants and the FSM state encodings (SEARCH, MEASURE, LOCKED), also used by the Hsync/Vsync generators.
- Sub-module sync_sampler: input register, delayed copy, falling-edge pulse; instantiated for HSYNC and VSYNC.

## Test plan
- Loopback Hsync/Vsync generator (small override: H 8/2/4/2, V 6/1/2/1) -> locked rises at end of second vsync-bounded frame; frame_start once per frame thereafter; err_count 0.
- Locked, active pixel at hcnt=H_OFF+3, vcnt=V_OFF+2 -> hpos=3, vpos=2, active=1, 2 clocks after matching input sample.
- Locked, one line stretched by 1 clock -> timing_error pulse at hcnt=H_TOTAL, locked=0, err_count=1; relock after two clean frames.
- Locked, frame with V_TOTAL+1 lines -> error on vsync line, state SEARCH, active stays 0 until relock.
- HSYNC held high -> after lock, error when hcnt hits H_TOTAL; in SEARCH no further errors; 300 forced failures -> err_count=255.
- Reset asserted mid-frame while locked -> next clock all outputs 0, err_count 0; vs_fall coincident with hs_fall -> vcnt=0, no false error.
